// File: rtl/ram_march_bist.sv
// March C- memory BIST controller: drives the RAM write/read pins, checks every read
// against the expected background and captures the first failing word.
module ram_march_bist #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 8,
    parameter int RD_LAT       = 1,
    parameter int STOP_ON_FAIL = 0,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [AW-1:0]    fail_addr,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_data,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] mem_q
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_DONE} state_e;
    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

    localparam int               CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0]    TOP = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] B0  = '0;
    localparam logic [WIDTH-1:0] B1  = '1;

    state_e           state;
    elem_e            elem;
    elem_e            nxt_elem;
    logic [CW-1:0]    wcnt;
    logic [AW-1:0]    nxt_addr;
    logic [WIDTH-1:0] exp_word;
    logic             elem_down;
    logic             nxt_rd;
    logic             seq_end;
    logic             cmp_now;
    logic             mismatch;
    logic             stop_now;

    // Works out the op that follows the current one, assuming the current op ends this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_elem  = elem;
        nxt_addr  = mem_addr;
        nxt_rd    = 1'b0;
        seq_end   = 1'b0;
        elem_down = (elem == M3) || (elem == M4);
        exp_word  = ((elem == M2) || (elem == M4)) ? B1 : B0;
        cmp_now   = ((state == S_RD) && (RD_LAT == 0)) || ((state == S_RWAIT) && (wcnt == '0));
        mismatch  = cmp_now && (mem_q != exp_word);
        stop_now  = mismatch && (STOP_ON_FAIL != 0);

        if ((state != S_WR) && (elem != M5)) begin
            nxt_rd = 1'b0;  // read half done: the write of the same address follows
        end else if (elem_down ? (mem_addr == '0) : (mem_addr == TOP)) begin
            if (elem == M5) begin
                seq_end = 1'b1;
            end else begin
                nxt_elem = elem_e'(elem + 3'd1);
                nxt_rd   = 1'b1;
                nxt_addr = ((elem == M2) || (elem == M3)) ? TOP : '0;
            end
        end else begin
            nxt_addr = elem_down ? (mem_addr - 1'b1) : (mem_addr + 1'b1);
            nxt_rd   = (elem != M0);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= S_IDLE;
            elem      <= M0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_data <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments so every
            // branch sees the pre-edge values of the other registers.
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_WR;
                        elem      <= M0;
                        busy      <= 1'b1;
                        mem_wen   <= 1'b1;
                        mem_ren   <= 1'b0;
                        mem_addr  <= '0;
                        mem_data  <= B0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_exp  <= '0;
                        fail_data <= '0;
                    end
                end
                S_WR, S_RD, S_RWAIT: begin
                    if (mismatch && !fail) begin
                        fail      <= 1'b1;
                        fail_addr <= mem_addr;
                        fail_exp  <= exp_word;
                        fail_data <= mem_q;
                    end
                    if ((state == S_RD) && (RD_LAT > 0)) begin
                        state   <= S_RWAIT;
                        mem_ren <= 1'b0;
                        wcnt    <= CW'(RD_LAT - 1);
                    end else if ((state == S_RWAIT) && (wcnt != '0)) begin
                        wcnt <= wcnt - 1'b1;
                    end else if (seq_end || stop_now) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_wen  <= 1'b0;
                        mem_ren  <= 1'b0;
                        mem_addr <= '0;
                        mem_data <= '0;
                    end else begin
                        state    <= nxt_rd ? S_RD : S_WR;
                        elem     <= nxt_elem;
                        mem_addr <= nxt_addr;
                        mem_wen  <= !nxt_rd;
                        mem_ren  <= nxt_rd;
                        mem_data <= ((nxt_elem == M1) || (nxt_elem == M3)) ? B1 : B0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: three configurations, RAM models with a stuck-at cell,
// and a March C- reference that walks the op list to predict timing and first failure.
module tb_ram_march_bist;

    logic                 clk   = 1'b0;
    logic                 res   = 1'b0;
    logic [2:0]           start = '0;
    logic [2:0]           busy, done, fail, mem_wen, mem_ren;
    logic [2:0][2:0]      fail_addr, mem_addr;
    logic [2:0][3:0]      fail_exp, fail_data, mem_data, mem_q;

    always #5 clk = ~clk;

    // 0: DEPTH 8, RD_LAT 1; 1: same with STOP_ON_FAIL; 2: DEPTH 1, RD_LAT 2
    ram_march_bist #(.WIDTH(4), .DEPTH(8), .RD_LAT(1), .STOP_ON_FAIL(0)) dut_a (
        .clk(clk), .res(res), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .fail(fail[0]), .fail_addr(fail_addr[0]), .fail_exp(fail_exp[0]),
        .fail_data(fail_data[0]), .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]),
        .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .mem_q(mem_q[0]));

    ram_march_bist #(.WIDTH(4), .DEPTH(8), .RD_LAT(1), .STOP_ON_FAIL(1)) dut_b (
        .clk(clk), .res(res), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .fail(fail[1]), .fail_addr(fail_addr[1]), .fail_exp(fail_exp[1]),
        .fail_data(fail_data[1]), .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]),
        .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .mem_q(mem_q[1]));

    ram_march_bist #(.WIDTH(4), .DEPTH(1), .RD_LAT(2), .STOP_ON_FAIL(0)) dut_c (
        .clk(clk), .res(res), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .fail(fail[2]), .fail_addr(fail_addr[2][0:0]), .fail_exp(fail_exp[2]),
        .fail_data(fail_data[2]), .mem_wen(mem_wen[2]), .mem_ren(mem_ren[2]),
        .mem_addr(mem_addr[2][0:0]), .mem_data(mem_data[2]), .mem_q(mem_q[2]));

    assign fail_addr[2][2:1] = 2'b00;
    assign mem_addr[2][2:1]  = 2'b00;

    // RAM models: one stuck-at cell per RAM, applied on read
    logic [3:0]      ram [3][8];
    logic [2:0][3:0] qp0 = '0;
    logic [2:0][3:0] qp1 = '0;
    int              f_en [3];
    int              f_addr [3];
    int              f_bit [3];
    int              f_val [3];

    function automatic logic [3:0] faulty(input int x, input int a, input logic [3:0] v);
        logic [3:0] m;
        m = 4'(1 << f_bit[x]);
        if (f_en[x] == 0 || a != f_addr[x]) return v;
        return (f_val[x] != 0) ? (v | m) : (v & ~m);
    endfunction

    always @(posedge clk) begin
        for (int x = 0; x < 3; x++) begin
            if (mem_wen[x]) ram[x][mem_addr[x]] <= mem_data[x];
            if (mem_ren[x]) qp0[x] <= faulty(x, int'(mem_addr[x]), ram[x][mem_addr[x]]);
            qp1[x] <= qp0[x];
        end
    end

    assign mem_q = {qp1[2], qp0[1], qp0[0]};

    // Cycle monitor
    int cyc = 0;
    int busy_cnt [3];
    int done_cnt [3];
    int done_cyc [3];
    int overlap_cnt [3];
    int idle_act [3];
    int addr_bad [3];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int x = 0; x < 3; x++) begin
            if (busy[x]) busy_cnt[x] <= busy_cnt[x] + 1;
            if (done[x]) begin
                done_cnt[x] <= done_cnt[x] + 1;
                done_cyc[x] <= cyc;
            end
            if (mem_wen[x] && mem_ren[x]) overlap_cnt[x] <= overlap_cnt[x] + 1;
            if (!busy[x] && (mem_wen[x] || mem_ren[x])) idle_act[x] <= idle_act[x] + 1;
            if (mem_addr[x] != 3'd0) addr_bad[x] <= addr_bad[x] + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs(input int x);
        return {9'd0, busy[x], done[x], fail[x], fail_addr[x], fail_exp[x], fail_data[x],
                mem_wen[x], mem_ren[x], mem_addr[x], mem_data[x]};
    endfunction

    // Reference: walk the March C- op list over a faulty cell array, counting cycles per op
    function automatic void march_model(input int x, output bit ef, output int ea,
                                        output int ee, output int ed, output int rel);
        int         depth = (x == 2) ? 1 : 8;
        int         rl    = (x == 2) ? 2 : 1;
        int         t     = 0;
        int         a;
        logic [3:0] m [8];
        logic [3:0] want, got;
        ef = 1'b0; ea = 0; ee = 0; ed = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < depth; j++) begin
                a = (e == 3 || e == 4) ? depth - 1 - j : j;
                if (e != 0) begin
                    want = (e == 2 || e == 4) ? 4'hF : 4'h0;
                    got  = faulty(x, a, m[a]);
                    t += rl + 1;
                    if (got != want && !ef) begin
                        ef = 1'b1; ea = a; ee = int'(want); ed = int'(got);
                        if (x == 1) begin
                            rel = t + 1;
                            return;
                        end
                    end
                end
                if (e != 5) begin
                    m[a] = (e == 1 || e == 3) ? 4'hF : 4'h0;
                    t++;
                end
            end
        end
        rel = t + 1;
    endfunction

    task automatic set_fault(input int x, input int en, input int a, input int b, input int v);
        f_en[x] = en; f_addr[x] = a; f_bit[x] = b; f_val[x] = v;
    endtask

    // Starts DUT x (start held `hold` cycles, plus one extra pulse at `repulse`) and
    // measures done position relative to the accepting edge.
    task automatic run(input int x, input int hold, input int repulse,
                       output int rel, output int nbusy, output int ndone);
        int base_d, base_b, k;
        bit seen;
        seen = 1'b0;
        rel  = -1;
        step();
        base_d = done_cnt[x];
        base_b = busy_cnt[x];
        k      = cyc + 1;
        for (int t = 0; t < 400 && !seen; t++) begin
            start[x] = (t < hold) || (t == repulse);
            step();
            seen = (done_cnt[x] != base_d);
        end
        start[x] = 1'b0;
        repeat (5) step();
        if (seen) rel = done_cyc[x] - k + 1;
        nbusy = busy_cnt[x] - base_b;
        ndone = done_cnt[x] - base_d;
    endtask

    task automatic verify(input int x, input string tag, input int hold, input int repulse,
                          output int rel);
        bit ef;
        int ea, ee, ed, erel, nb, nd, b_ov, b_ia, b_ab;
        march_model(x, ef, ea, ee, ed, erel);
        b_ov = overlap_cnt[x];
        b_ia = idle_act[x];
        b_ab = addr_bad[x];
        run(x, hold, repulse, rel, nb, nd);
        check($sformatf("%s_done_rel", tag), rel, erel);
        check($sformatf("%s_busy_cycles", tag), nb, erel - 1);
        check($sformatf("%s_done_pulses", tag), nd, 1);
        check($sformatf("%s_fail_flag", tag), {31'd0, fail[x]}, {31'd0, ef});
        if (ef) begin
            check($sformatf("%s_fail_addr", tag), {29'd0, fail_addr[x]}, ea);
            check($sformatf("%s_fail_exp", tag), {28'd0, fail_exp[x]}, ee);
            check($sformatf("%s_fail_data", tag), {28'd0, fail_data[x]}, ed);
        end
        check($sformatf("%s_wen_ren_overlap", tag), overlap_cnt[x] - b_ov, 0);
        check($sformatf("%s_mem_active_idle", tag), idle_act[x] - b_ia, 0);
        if (x == 2) check($sformatf("%s_addr_nonzero", tag), addr_bad[x] - b_ab, 0);
    endtask

    initial begin
        int rel, base_d, x, depth;
        for (int i = 0; i < 3; i++) set_fault(i, 0, 0, 0, 0);

        repeat (3) step();
        for (int i = 0; i < 3; i++) check($sformatf("reset_outs_%0d", i), outs(i), 32'd0);
        res = 1'b1;
        step();

        // Ideal RAM, full run
        verify(0, "ideal", 1, -1, rel);
        check("ideal_rel_121", rel, 121);

        // Bit 2 of address 5 stuck at 1: first hit in M1, run completes
        set_fault(0, 1, 5, 2, 1);
        verify(0, "sa1", 1, -1, rel);
        check("sa1_rel_121", rel, 121);
        check("sa1_addr5", {29'd0, fail_addr[0]}, 5);
        check("sa1_data4", {28'd0, fail_data[0]}, 4);

        // Same fault, stop on first failure
        set_fault(1, 1, 5, 2, 1);
        verify(1, "stop", 1, -1, rel);
        check("stop_rel_26", rel, 26);

        // Reset in the middle of a run
        set_fault(0, 0, 0, 0, 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (49) step();
        base_d = done_cnt[0];
        #2 res = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("midrun_reset_outs_%0d", i), outs(i), 32'd0);
        repeat (3) step();
        check("midrun_no_done", done_cnt[0] - base_d, 0);
        res = 1'b1;
        step();
        verify(0, "after_reset", 1, -1, rel);
        check("after_reset_rel_121", rel, 121);

        // Faulty run, then a held start with a mid-run repulse on a healthy RAM
        set_fault(0, 1, 2, 0, 0);
        verify(0, "sa0", 1, -1, rel);
        set_fault(0, 0, 0, 0, 0);
        verify(0, "hold", 10, 60, rel);
        check("hold_rel_121", rel, 121);

        // Single-word RAM with a two-cycle read
        verify(2, "d1", 1, -1, rel);
        check("d1_rel_21", rel, 21);

        // Randomized configurations and faults
        for (int i = 0; i < 8; i++) begin
            x     = int'($urandom_range(2, 0));
            depth = (x == 2) ? 1 : 8;
            set_fault(x, ($urandom_range(3, 0) != 0) ? 1 : 0, int'($urandom_range(depth - 1, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(1, 0)));
            verify(x, $sformatf("rnd%0d_dut%0d", i, x), int'($urandom_range(3, 1)), -1, rel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
